// File: rtl/btrain_mux_pkg.sv
// Shared types, word-field layout and packing helper for the BTrain frame mux.
// Imported by btrain_bvalue_counter and btrain_bframe_tx_mux.
package btrain_mux_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } t_tx_state;

    localparam int C_VAL_LSB = 0;
    localparam int C_VAL_W   = 32;
    localparam int C_CH_LSB  = 32;
    localparam int C_CH_W    = 8;
    localparam int C_C0_BIT  = 40;
    localparam int C_SEQ_LSB = 48;
    localparam int C_SEQ_W   = 8;
    localparam int C_WORD_W  = 64;

    // Value must already be sign-extended to 32 bits by the caller.
    function automatic logic [C_WORD_W-1:0] f_pack_bword(
        input logic [C_VAL_W-1:0] value,
        input logic [C_CH_W-1:0]  ch,
        input logic               c0,
        input logic [C_SEQ_W-1:0] seq
    );
        logic [C_WORD_W-1:0] w;
        w = '0;
        w[C_VAL_LSB +: C_VAL_W] = value;
        w[C_CH_LSB +: C_CH_W]   = ch;
        w[C_C0_BIT]             = c0;
        w[C_SEQ_LSB +: C_SEQ_W] = seq;
        return w;
    endfunction

endpackage

// File: rtl/btrain_bvalue_counter.sv
// Per-channel saturating signed B counter with sticky C0 flag.
// Ports: clk/rst, up/down/c0 pulses, snap_i clears the flag; value_o, c0_flag_o.
module btrain_bvalue_counter
    import btrain_mux_pkg::*;
#(
    parameter int g_bvalue_width = 32,
    parameter int g_step         = 1
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_sys_i,
    input  logic                      up_i,
    input  logic                      down_i,
    input  logic                      c0_i,
    input  logic                      snap_i,
    output logic [g_bvalue_width-1:0] value_o,
    output logic                      c0_flag_o
);

    localparam int W = g_bvalue_width;

    // Two guard bits so a step never wraps before the saturation compare.
    typedef logic signed [W+1:0] t_ext;

    localparam t_ext C_MAX  = {3'b000, {(W-1){1'b1}}};
    localparam t_ext C_MIN  = {3'b111, {(W-1){1'b0}}};
    localparam t_ext C_STEP = t_ext'(g_step);

    t_ext          cur;
    t_ext          inc;
    t_ext          dec;
    logic [W-1:0]  nxt;

    always_comb begin
        cur = t_ext'(signed'(value_o));
        inc = cur + C_STEP;
        dec = cur - C_STEP;
        nxt = value_o;
        if (c0_i) begin
            nxt = '0;
        end else if (up_i && !down_i) begin
            nxt = (inc > C_MAX) ? C_MAX[W-1:0] : inc[W-1:0];
        end else if (down_i && !up_i) begin
            nxt = (dec < C_MIN) ? C_MIN[W-1:0] : dec[W-1:0];
        end
    end

    // The snapshot already captured c0_flag|c0_i, so clearing wins.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            value_o   <= '0;
            c0_flag_o <= 1'b0;
        end else begin
            value_o <= nxt;
            if (snap_i) begin
                c0_flag_o <= 1'b0;
            end else if (c0_i) begin
                c0_flag_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/btrain_bframe_tx_mux.sv
// N-channel BTrain B-value frame generator feeding the WR streamer TX port.
// Ports: pulses in, tx_en/tx_dreq in; tx word/valid/last, live values, stats out.
module btrain_bframe_tx_mux
    import btrain_mux_pkg::*;
#(
    parameter int g_num_channels = 2,
    parameter int g_bvalue_width = 32,
    parameter int g_data_width   = 64,
    parameter int g_frame_period = 1000,
    parameter int g_step         = 1
) (
    input  logic                                     clk_sys_i,
    input  logic                                     rst_sys_i,
    input  logic [g_num_channels-1:0]                up_i,
    input  logic [g_num_channels-1:0]                down_i,
    input  logic [g_num_channels-1:0]                c0_i,
    input  logic                                     tx_en_i,
    input  logic                                     tx_dreq_i,
    output logic [g_data_width-1:0]                  tx_data_o,
    output logic                                     tx_valid_o,
    output logic                                     tx_last_p1_o,
    output logic [g_num_channels*g_bvalue_width-1:0] bvalue_o,
    output logic [15:0]                              frames_sent_o,
    output logic [15:0]                              overruns_o
);

    localparam int N  = g_num_channels;
    localparam int W  = g_bvalue_width;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(g_frame_period);

    localparam logic [PW-1:0] C_CNT_LAST = PW'(g_frame_period - 1);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(N - 1);

    logic [PW-1:0]        period_cnt;
    logic                 tick;
    logic                 snap;
    logic [N-1:0][W-1:0]  vals;
    logic [N-1:0]         flags;
    logic [N-1:0][W-1:0]  snap_val;
    logic [N-1:0]         snap_c0;
    logic [7:0]           seq;
    logic [7:0]           snap_seq;
    t_tx_state            state;
    t_tx_state            state_d;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_d;
    logic                 emit;
    logic                 last_word;
    logic [g_data_width-1:0] tx_word;

    assign tick     = tx_en_i && (period_cnt == C_CNT_LAST);
    assign snap     = tick && (state == IDLE);
    assign bvalue_o = vals;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i || !tx_en_i || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        btrain_bvalue_counter #(
            .g_bvalue_width (W),
            .g_step         (g_step)
        ) u_cnt (
            .clk_sys_i (clk_sys_i),
            .rst_sys_i (rst_sys_i),
            .up_i      (up_i[g]),
            .down_i    (down_i[g]),
            .c0_i      (c0_i[g]),
            .snap_i    (snap),
            .value_o   (vals[g]),
            .c0_flag_o (flags[g])
        );
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        emit      = 1'b0;
        last_word = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (tx_dreq_i) begin
                    emit = 1'b1;
                    if (idx == C_IDX_LAST) begin
                        last_word = 1'b1;
                        state_d   = IDLE;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_word = g_data_width'(f_pack_bword(
        32'(signed'(snap_val[idx])), 8'(idx), snap_c0[idx], snap_seq));

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            tx_data_o     <= '0;
            tx_valid_o    <= 1'b0;
            tx_last_p1_o  <= 1'b0;
            snap_val      <= '0;
            snap_c0       <= '0;
            snap_seq      <= '0;
            seq           <= '0;
            frames_sent_o <= '0;
            overruns_o    <= '0;
        end else begin
            tx_valid_o   <= emit;
            tx_last_p1_o <= last_word;
            if (emit) begin
                tx_data_o <= tx_word;
            end
            // Counters are sampled before this edge's pulses apply.
            if (snap) begin
                snap_val <= vals;
                snap_c0  <= flags | c0_i;
                snap_seq <= seq;
                seq      <= seq + 8'd1;
            end
            if (tick && (state != IDLE) && (overruns_o != 16'hffff)) begin
                overruns_o <= overruns_o + 16'd1;
            end
            if (last_word && (frames_sent_o != 16'hffff)) begin
                frames_sent_o <= frames_sent_o + 16'd1;
            end
        end
    end

endmodule
